pipe_stage_skid: RTL

//   Parametrised pipeline stage register, successor of the fixed 4x32 ID/EX register.

---
 rtl/pipe_stage_skid.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Parametrised valid/ready pipeline stage with optional 2-entry skid buffer,
// flush (kill everything held plus this cycle's input) and bubble (stall + nop) controls.
module pipe_stage_skid #(
    parameter int                  FIELD_W    = 32,
    parameter int                  NUM_FIELDS = 4,
    parameter logic [FIELD_W-1:0]  BUBBLE_VAL = '0,
    parameter bit                  SKID_EN    = 1'b1,
    localparam int                 W          = FIELD_W * NUM_FIELDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    input  logic         bubble,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    localparam logic [W-1:0] BUBBLE = {NUM_FIELDS{BUBBLE_VAL}};

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t       state, state_nx;
    logic [W-1:0] main_q, main_nx;
    logic [W-1:0] skid_q, skid_nx;
    logic [1:0]   occ_nx;
    logic         acc, deq;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign deq       = out_valid & out_ready;
    assign acc       = in_valid & in_ready;

    // With the skid entry, in_ready depends only on flops so out_ready never
    // reaches the upstream handshake combinationally.
    generate
        if (SKID_EN) begin : g_skid
            assign in_ready = (state != SKID) & ~bubble & ~rst;
        end else begin : g_single
            assign in_ready = (~out_valid | out_ready) & ~bubble & ~rst;
        end
    endgenerate

    always_comb begin
        state_nx = state;
        main_nx  = main_q;
        skid_nx  = skid_q;
        if (flush) begin
            state_nx = EMPTY;
            main_nx  = BUBBLE;
            skid_nx  = BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nx = FULL;
                        main_nx  = in_data;
                    end
                end
                FULL: begin
                    if (acc && deq) begin
                        main_nx = in_data;
                    end else if (acc && SKID_EN) begin
                        state_nx = SKID;
                        skid_nx  = in_data;
                    end else if (deq) begin
                        state_nx = EMPTY;
                        main_nx  = BUBBLE;
                    end
                end
                SKID: begin
                    if (deq) begin
                        state_nx = FULL;
                        main_nx  = skid_q;
                        skid_nx  = BUBBLE;
                    end
                end
                default: begin
                    state_nx = EMPTY;
                    main_nx  = BUBBLE;
                    skid_nx  = BUBBLE;
                end
            endcase
        end
    end

    always_comb begin
        occ_nx = 2'd0;
        case (state_nx)
            FULL:    occ_nx = 2'd1;
            SKID:    occ_nx = 2'd2;
            default: occ_nx = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= BUBBLE;
            skid_q    <= BUBBLE;
            occupancy <= 2'd0;
        end else begin
            state     <= state_nx;
            main_q    <= main_nx;
            skid_q    <= skid_nx;
            occupancy <= occ_nx;
        end
    end

endmodule
